// File: rtl/ahb_lite_decode_mux.sv
// AHB-Lite single-master decode/response slice: address decode to N slaves,
// registered data-phase select, response mux and a built-in ERROR default slave.
module ahb_lite_decode_mux #(
    parameter int unsigned                NUM_SLAVES = 3,
    parameter logic [NUM_SLAVES*32-1:0]   SLV_BASE   = {32'h1F800000, 32'h00000000, 32'h1FC00000},
    parameter logic [NUM_SLAVES*32-1:0]   SLV_MASK   = {32'h1FC00000, 32'h10000000, 32'h1FC00000},
    parameter int unsigned                CNT_W      = 8
) (
    input  logic                       HCLK,
    input  logic                       HRESETn,
    input  logic [31:0]                HADDR,
    input  logic [1:0]                 HTRANS,
    output logic [NUM_SLAVES-1:0]      HSEL,
    input  logic [NUM_SLAVES*32-1:0]   HRDATA_S,
    input  logic [NUM_SLAVES-1:0]      HREADYOUT_S,
    input  logic [NUM_SLAVES-1:0]      HRESP_S,
    output logic [31:0]                HRDATA,
    output logic                       HREADY,
    output logic                       HRESP,
    output logic [CNT_W-1:0]           DECERR_CNT
);

    localparam int unsigned DW = 32;

    typedef enum logic [1:0] {
        DS_IDLE = 2'd0,
        DS_ERR1 = 2'd1,
        DS_ERR2 = 2'd2
    } ds_state_t;

    // Reject unsupported slave counts at elaboration
    if (NUM_SLAVES < 1 || NUM_SLAVES > 8) begin : g_bad_num_slaves
        $fatal(1, "ahb_lite_decode_mux: NUM_SLAVES must be in 1..8");
    end

    logic [NUM_SLAVES-1:0] hsel_dec;
    logic                  miss;
    logic [NUM_SLAVES-1:0] sel_dp;
    logic                  def_dp;
    ds_state_t             ds_state;
    ds_state_t             ds_next;
    logic                  ds_ready;
    logic                  ds_resp;
    logic                  err_entry;
    logic                  slv_active;
    logic [DW-1:0]         slv_rdata;
    logic                  slv_ready;
    logic                  slv_resp;
    logic [CNT_W-1:0]      err_cnt;
    logic                  unused_htrans0;

    assign unused_htrans0 = HTRANS[0];

    // Address decode: lowest-index match wins, independent of HTRANS
    always_comb begin
        hsel_dec = '0;
        miss     = 1'b1;
        for (int unsigned i = 0; i < NUM_SLAVES; i++) begin
            if (miss && ((HADDR & SLV_MASK[32*i +: 32]) == SLV_BASE[32*i +: 32])) begin
                hsel_dec[i] = 1'b1;
                miss        = 1'b0;
            end
        end
    end

    assign HSEL = hsel_dec;

    // Data-phase select, captured only when the bus accepts an address phase
    always_ff @(posedge HCLK or negedge HRESETn) begin
        if (!HRESETn) begin
            sel_dp <= '0;
            def_dp <= 1'b0;
        end else if (HREADY) begin
            sel_dp <= hsel_dec;
            def_dp <= miss;
        end
    end

    // Selected-slave response; ready reads 1 when no mapped slave owns the data phase
    always_comb begin
        slv_active = 1'b0;
        slv_rdata  = '0;
        slv_ready  = 1'b1;
        slv_resp   = 1'b0;
        for (int unsigned i = 0; i < NUM_SLAVES; i++) begin
            if (!def_dp && sel_dp[i]) begin
                slv_active = 1'b1;
                slv_rdata  = HRDATA_S[32*i +: 32];
                slv_ready  = HREADYOUT_S[i];
                slv_resp   = HRESP_S[i];
            end
        end
    end

    // Master-side response mux: mapped slave or default slave
    always_comb begin
        HRDATA = slv_rdata;
        HREADY = slv_active ? slv_ready : ds_ready;
        HRESP  = slv_active ? slv_resp  : ds_resp;
    end

    // Default slave state register
    always_ff @(posedge HCLK or negedge HRESETn) begin
        if (!HRESETn) begin
            ds_state <= DS_IDLE;
        end else begin
            ds_state <= ds_next;
        end
    end

    // Default slave next state and outputs; in IDLE its own ready is 1, so slv_ready equals HREADY
    always_comb begin
        ds_next   = ds_state;
        ds_ready  = 1'b1;
        ds_resp   = 1'b0;
        err_entry = 1'b0;
        case (ds_state)
            DS_IDLE: begin
                if (slv_ready && miss && HTRANS[1]) begin
                    ds_next   = DS_ERR1;
                    err_entry = 1'b1;
                end
            end
            DS_ERR1: begin
                ds_ready = 1'b0;
                ds_resp  = 1'b1;
                ds_next  = DS_ERR2;
            end
            DS_ERR2: begin
                ds_resp = 1'b1;
                if (miss && HTRANS[1]) begin
                    ds_next   = DS_ERR1;
                    err_entry = 1'b1;
                end else begin
                    ds_next = DS_IDLE;
                end
            end
            default: begin
                ds_next = DS_IDLE;
            end
        endcase
    end

    // Saturating count of unmapped active transfers
    always_ff @(posedge HCLK or negedge HRESETn) begin
        if (!HRESETn) begin
            err_cnt <= '0;
        end else if (err_entry && (err_cnt != {CNT_W{1'b1}})) begin
            err_cnt <= err_cnt + CNT_W'(1);
        end
    end

    assign DECERR_CNT = err_cnt;

endmodule

// File: tb/tb_ahb_lite_decode_mux.sv
// Directed bench for ahb_lite_decode_mux with a queue-based scoreboard.
module tb_ahb_lite_decode_mux;

    logic        HCLK = 1'b0;
    logic        HRESETn;
    logic [31:0] HADDR;
    logic [1:0]  HTRANS;
    logic [2:0]  rdy_s;
    logic [31:0] s1data;

    logic [2:0]  hsel;
    logic [31:0] hrdata;
    logic        hready;
    logic        hresp;
    logic [7:0]  cnt;

    logic [2:0]  sat_hsel;
    logic [31:0] sat_hrdata;
    logic        sat_hready;
    logic        sat_hresp;
    logic [1:0]  sat_cnt;

    logic [1:0]  ov_hsel;
    logic [31:0] ov_hrdata;
    logic        ov_hready;
    logic        ov_hresp;
    logic [7:0]  ov_cnt;

    typedef struct {
        string       tag;
        logic [2:0]  hsel;
        logic        rdy;
        logic        resp;
        logic [31:0] data;
        logic [7:0]  cnt;
        logic [1:0]  sat;
    } exp_t;

    exp_t q[$];
    event smp;
    int   n_cmp = 0;
    int   n_bad = 0;

    always #5 HCLK = ~HCLK;

    ahb_lite_decode_mux dut (
        .HCLK(HCLK), .HRESETn(HRESETn), .HADDR(HADDR), .HTRANS(HTRANS), .HSEL(hsel),
        .HRDATA_S({32'h22220000, s1data, 32'h11110000}), .HREADYOUT_S(rdy_s), .HRESP_S(3'b000),
        .HRDATA(hrdata), .HREADY(hready), .HRESP(hresp), .DECERR_CNT(cnt)
    );

    ahb_lite_decode_mux #(.CNT_W(2)) dut_sat (
        .HCLK(HCLK), .HRESETn(HRESETn), .HADDR(HADDR), .HTRANS(HTRANS), .HSEL(sat_hsel),
        .HRDATA_S({32'h22220000, s1data, 32'h11110000}), .HREADYOUT_S(rdy_s), .HRESP_S(3'b000),
        .HRDATA(sat_hrdata), .HREADY(sat_hready), .HRESP(sat_hresp), .DECERR_CNT(sat_cnt)
    );

    ahb_lite_decode_mux #(.NUM_SLAVES(2), .SLV_BASE(64'h0), .SLV_MASK(64'h0)) dut_ov (
        .HCLK(HCLK), .HRESETn(HRESETn), .HADDR(HADDR), .HTRANS(HTRANS), .HSEL(ov_hsel),
        .HRDATA_S(64'h0), .HREADYOUT_S(2'b11), .HRESP_S(2'b00),
        .HRDATA(ov_hrdata), .HREADY(ov_hready), .HRESP(ov_hresp), .DECERR_CNT(ov_cnt)
    );

    function automatic void chk(string tag, string fld, logic [31:0] act, logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s.%s: got %h want %h", tag, fld, act, exp);
        end
    endfunction

    function automatic void push(string tag, logic [2:0] hs, logic r, logic rs,
                                 logic [31:0] d, logic [7:0] c, logic [1:0] sc);
        exp_t e;
        e.tag = tag; e.hsel = hs; e.rdy = r; e.resp = rs; e.data = d; e.cnt = c; e.sat = sc;
        q.push_back(e);
    endfunction

    // Monitor: pop one expectation per sample point and compare all outputs
    initial begin
        exp_t e;
        forever begin
            @(negedge HCLK or smp);
            if (q.size() > 0) begin
                e = q.pop_front();
                chk(e.tag, "hsel",    32'(hsel),    32'(e.hsel));
                chk(e.tag, "hready",  32'(hready),  32'(e.rdy));
                chk(e.tag, "hresp",   32'(hresp),   32'(e.resp));
                chk(e.tag, "hrdata",  hrdata,       e.data);
                chk(e.tag, "cnt",     32'(cnt),     32'(e.cnt));
                chk(e.tag, "cnt_sat", 32'(sat_cnt), 32'(e.sat));
                chk(e.tag, "hsel_ov", 32'(ov_hsel), 32'(2'b01));
            end
        end
    end

    task automatic step(string tag, logic [31:0] a, logic [1:0] t, logic [2:0] rdy, logic [31:0] s1,
                        logic [2:0] hs, logic r, logic rs, logic [31:0] d, logic [7:0] c, logic [1:0] sc);
        @(posedge HCLK);
        #1;
        HADDR = a; HTRANS = t; rdy_s = rdy; s1data = s1;
        push(tag, hs, r, rs, d, c, sc);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout want finish");
        $fatal(1, "watchdog");
    end

    // Directed stimulus; expected values computed by hand from the default map
    initial begin
        HRESETn = 1'b0; HADDR = 32'hBF400000; HTRANS = 2'b00; rdy_s = 3'b111; s1data = 32'h33330000;
        #2;
        push("rst0", 3'b000, 1'b1, 1'b0, 32'h0, 8'd0, 2'd0);
        #1 -> smp;
        @(posedge HCLK); #1 HRESETn = 1'b1;

        step("dec0",  32'hBFC00010, 2'b00, 3'b111, 32'h33330000, 3'b001, 1, 0, 32'h00000000, 0, 0);
        step("dec1",  32'h80000100, 2'b00, 3'b111, 32'h33330000, 3'b010, 1, 0, 32'h11110000, 0, 0);
        step("dec2",  32'hBF800004, 2'b00, 3'b111, 32'h33330000, 3'b100, 1, 0, 32'h33330000, 0, 0);
        step("decm",  32'hBF400000, 2'b00, 3'b111, 32'h33330000, 3'b000, 1, 0, 32'h22220000, 0, 0);
        step("idlm",  32'h80000100, 2'b10, 3'b111, 32'h33330000, 3'b010, 1, 0, 32'h00000000, 0, 0);
        step("wait1", 32'hBFC00000, 2'b00, 3'b101, 32'h33330000, 3'b001, 0, 0, 32'h33330000, 0, 0);
        step("wait2", 32'hBFC00000, 2'b00, 3'b101, 32'h33330000, 3'b001, 0, 0, 32'h33330000, 0, 0);
        step("wdone", 32'hBFC00000, 2'b00, 3'b111, 32'hDEADBEEF, 3'b001, 1, 0, 32'hDEADBEEF, 0, 0);
        step("sel0",  32'hBF400000, 2'b10, 3'b111, 32'hDEADBEEF, 3'b000, 1, 0, 32'h11110000, 0, 0);
        step("err1",  32'hBFC00010, 2'b00, 3'b111, 32'hDEADBEEF, 3'b001, 0, 1, 32'h00000000, 1, 1);
        step("err2",  32'hBFC00010, 2'b00, 3'b111, 32'hDEADBEEF, 3'b001, 1, 1, 32'h00000000, 1, 1);
        step("okay",  32'h80000100, 2'b00, 3'b111, 32'hDEADBEEF, 3'b010, 1, 0, 32'h11110000, 1, 1);
        step("b2b0",  32'hBF400000, 2'b10, 3'b111, 32'hDEADBEEF, 3'b000, 1, 0, 32'hDEADBEEF, 1, 1);
        step("b2b1a", 32'hBF400000, 2'b10, 3'b111, 32'hDEADBEEF, 3'b000, 0, 1, 32'h00000000, 2, 2);
        step("b2b1b", 32'hBF400000, 2'b10, 3'b111, 32'hDEADBEEF, 3'b000, 1, 1, 32'h00000000, 2, 2);
        step("b2b2a", 32'hBF400000, 2'b10, 3'b111, 32'hDEADBEEF, 3'b000, 0, 1, 32'h00000000, 3, 3);
        step("b2b2b", 32'hBF400000, 2'b10, 3'b111, 32'hDEADBEEF, 3'b000, 1, 1, 32'h00000000, 3, 3);
        step("b2b3a", 32'hBF400000, 2'b10, 3'b111, 32'hDEADBEEF, 3'b000, 0, 1, 32'h00000000, 4, 3);
        step("b2b3b", 32'hBF400000, 2'b10, 3'b111, 32'hDEADBEEF, 3'b000, 1, 1, 32'h00000000, 4, 3);
        step("b2b4a", 32'hBF400000, 2'b10, 3'b111, 32'hDEADBEEF, 3'b000, 0, 1, 32'h00000000, 5, 3);
        step("b2b4b", 32'hBF400000, 2'b10, 3'b111, 32'hDEADBEEF, 3'b000, 1, 1, 32'h00000000, 5, 3);
        step("b2b5a", 32'hBF400000, 2'b10, 3'b111, 32'hDEADBEEF, 3'b000, 0, 1, 32'h00000000, 6, 3);
        step("b2b5b", 32'h80000100, 2'b00, 3'b111, 32'hDEADBEEF, 3'b010, 1, 1, 32'h00000000, 6, 3);
        step("b2bok", 32'hBF400000, 2'b10, 3'b111, 32'hDEADBEEF, 3'b000, 1, 0, 32'hDEADBEEF, 6, 3);
        step("preR",  32'hBF400000, 2'b10, 3'b111, 32'hDEADBEEF, 3'b000, 0, 1, 32'h00000000, 7, 3);

        // Asynchronous reset in the middle of ERR1, sampled before the next clock edge
        #6;
        HRESETn = 1'b0;
        push("rstE1", 3'b000, 1'b1, 1'b0, 32'h0, 8'd0, 2'd0);
        #1 -> smp;
        @(posedge HCLK); #1;
        HADDR = 32'h80000100; HTRANS = 2'b00;
        push("rstHs", 3'b010, 1'b1, 1'b0, 32'h0, 8'd0, 2'd0);
        #1 -> smp;
        @(posedge HCLK); #1 HRESETn = 1'b1;

        step("post0", 32'hBF400000, 2'b10, 3'b111, 32'hDEADBEEF, 3'b000, 1, 0, 32'hDEADBEEF, 0, 0);
        step("post1", 32'h80000100, 2'b00, 3'b111, 32'hDEADBEEF, 3'b010, 0, 1, 32'h00000000, 1, 1);
        step("post2", 32'h80000100, 2'b00, 3'b111, 32'hDEADBEEF, 3'b010, 1, 1, 32'h00000000, 1, 1);
        step("post3", 32'h80000100, 2'b00, 3'b111, 32'hDEADBEEF, 3'b010, 1, 0, 32'hDEADBEEF, 1, 1);

        repeat (3) @(posedge HCLK);
        n_cmp++;
        if (q.size() != 0) begin
            n_bad++;
            $display("FAIL drain: got %0d pending want 0", q.size());
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/ahb_lite_decode_mux.md
Name: ahb_lite_decode_mux

Overview:
- Parametrised AHB-Lite interconnect slice for the single-master CPU bus. Generalises the fixed three-slave HSEL decoder.
- Decodes HADDR against per-slave base/mask pairs to produce HSEL for N slaves.
- Registers the data-phase selection and multiplexes slave HRDATA/HREADYOUT/HRESP back to the master.
- Contains a built-in default slave that returns the two-cycle AHB ERROR response for unmapped active transfers, plus a saturating decode-error counter.

Parameters:
- NUM_SLAVES, 3, number of mapped slaves (1..8).
- SLV_BASE, {32'h1F800000, 32'h00000000, 32'h1FC00000}, packed NUM_SLAVES*32 match values; slave i occupies bits [32*i+31:32*i].
- SLV_MASK, {32'h1FC00000, 32'h10000000, 32'h1FC00000}, packed NUM_SLAVES*32 compare masks, same packing.
- CNT_W, 8, width of the decode-error counter.

Ports:
- HCLK  input  1  bus clock.
- HRESETn  input  1  asynchronous active-low reset.
- HADDR  input  32  master address-phase address.
- HTRANS  input  2  master transfer type; HTRANS[1]=1 means NONSEQ/SEQ.
- HSEL  output  NUM_SLAVES  address-phase slave selects, one-hot or zero.
- HRDATA_S  input  NUM_SLAVES*32  slave read data, packed.
- HREADYOUT_S  input  NUM_SLAVES  per-slave ready.
- HRESP_S  input  NUM_SLAVES  per-slave response (1=ERROR).
- HRDATA  output  32  muxed read data to master.
- HREADY  output  1  bus ready; also fed to all slaves.
- HRESP  output  1  muxed response.
- DECERR_CNT  output  CNT_W  count of unmapped active transfers, saturating.

Behaviour:
- Reset: asynchronous on HRESETn low, as fixed for this block. Clears all state immediately, including mid-transfer.
  - Post-reset outputs: data-phase select = none, DS state = DS_IDLE, HREADY=1, HRESP=0, HRDATA=32'h0, DECERR_CNT=0.
  - HSEL is combinational and follows HADDR even during reset.
- Address decode (combinational):
  - match_i = ((HADDR & SLV_MASK_i) == SLV_BASE_i).
  - HSEL = one-hot of the lowest-index match; overlapping regions resolve to the lowest index.
  - HSEL is independent of HTRANS.
  - miss = no match.
- Data-phase register, updated on HCLK rising edge only when HREADY=1:
  - sel_dp <= one-hot of HSEL.
  - def_dp <= miss.
  - While HREADY=0, sel_dp/def_dp hold, so a wait-stated transfer keeps its slave selected.
- Response mux:
  - sel_dp[i]=1: HRDATA=HRDATA_S[i], HREADY=HREADYOUT_S[i], HRESP=HRESP_S[i].
  - Otherwise (none or default): HRDATA=0; HREADY/HRESP come from the default slave.
- Default slave FSM, advances on HCLK:
  - DS_IDLE: outputs HREADY=1, HRESP=0. Goes to DS_ERR1 when HREADY=1 & miss & HTRANS[1]. IDLE/BUSY to an unmapped address gives a zero-wait OKAY.
  - DS_ERR1: outputs HREADY=0, HRESP=1. Always goes to DS_ERR2 next cycle.
  - DS_ERR2: outputs HREADY=1, HRESP=1.
    - Goes to DS_ERR1 if miss & HTRANS[1], covering back-to-back unmapped transfers.
    - Otherwise goes to DS_IDLE, and the new mapped transfer proceeds normally.
- Error response length: exactly two data-phase cycles per unmapped active transfer, never more or fewer.
- DECERR_CNT: +1 on each entry into DS_ERR1; saturates at 2^CNT_W-1 and never wraps.
- Latency:
  - HSEL: zero cycles.
  - Data-phase mux: follows the registered select one cycle after address-phase acceptance.
- Elaboration: parameters with NUM_SLAVES outside 1..8 are a fatal elaboration error.

Test Plan:
1. Reset check: assert HRESETn=0 mid-ERR1 -> HREADY=1, HRESP=0, HRDATA=0, DECERR_CNT=0 immediately, without waiting for a clock edge. Release -> DS_IDLE.
2. Default map decode:
   - HADDR=0xBFC00010 -> HSEL=3'b001.
   - HADDR=0x80000100 -> HSEL=3'b010.
   - HADDR=0xBF800004 -> HSEL=3'b100.
   - HADDR=0xBF400000 -> HSEL=3'b000.
3. Wait-stated read from slave 1:
   - Stimulus: NONSEQ to 0x80000100. In the data phase, HREADYOUT_S[1]=0 for 2 cycles while HADDR changes to 0xBFC00000, then HREADYOUT_S[1]=1 with HRDATA_S[1]=0xDEADBEEF.
   - Required: HREADY=0 for 2 cycles; HRDATA=0xDEADBEEF on the completing cycle; sel_dp switches to slave 0 only after that cycle.
4. Unmapped NONSEQ to 0xBF400000 -> next cycle HREADY=0/HRESP=1, then HREADY=1/HRESP=1, then OKAY. DECERR_CNT=1.
5. IDLE (HTRANS=2'b00) to 0xBF400000 -> zero-wait OKAY, DECERR_CNT unchanged.
6. Overlap and saturation:
   - Overlap: NUM_SLAVES=2 with both slaves at base 0, mask 0 -> HSEL=2'b01.
   - Saturation: CNT_W=2 with 5 back-to-back unmapped NONSEQs -> 5 ERR1/ERR2 pairs with no idle gap; DECERR_CNT stops at 3.
